aq_div32_seq: RTL and testbench

//  Request/response sequencer wrapped around the 33-stage aq_div32x32 pipeline. The divider has no valid or stall.
//  - Upstream: accepts operand requests on a valid/ready handshake; optionally converts signed operands to magnitudes.
//  - Drives the divider and tracks each in-flight slot in a matched side pipeline.
//  - Downstream: fixes up the quotient and buffers it in an output FIFO, so results are delivered without loss.
//  - Credit counting limits in-flight plus buffered results to the FIFO depth, so the pipeline never overruns it.

---
 rtl/aq_div32_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_aq_div32_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aq_div32_seq
//  Description : Request/response sequencer for the fixed-latency, stall-free
//                aq_div32x32 divider pipeline. It accepts operands on a
//                valid/ready handshake and drives the divider from registers.
//                A side pipeline that matches the divider latency carries
//                tag, sign and divide-by-zero flags for each slot. On the
//                divider output it fixes up the quotient and writes it to a
//                first-word-fall-through output FIFO. A credit counter limits
//                in-flight plus buffered results to the FIFO depth, so the
//                FIFO can never overflow.
//  Option      : AQ_DIV_SIGNED_EN - when defined, IN_SIGNED=1 requests are
//                divided as two's-complement numbers. The divider receives
//                magnitudes, and the sign is restored on the way out. When
//                undefined, IN_SIGNED is ignored and no sign logic is built.
//  Ports       : RST_N/CLK            async active-low reset, clock
//                IN_VALID/IN_READY    request handshake
//                IN_DINA/IN_DINB      dividend / divisor
//                IN_SIGNED/IN_TAG     signed-mode flag, user tag
//                DIV_DINA/DIV_DINB    registered operands to the divider
//                DIV_DOUT             quotient magnitude from the divider
//                OUT_VALID/OUT_READY  result handshake (FIFO head)
//                OUT_DATA/OUT_TAG     quotient and matching tag
//                OUT_DIVZ             divisor was zero
//  Revision    : 1.0  initial release
// ============================================================================
module aq_div32_seq #(
   parameter int DIV_LAT    = 33,
   parameter int FIFO_DEPTH = 64,
   parameter int TAG_W      = 4
) (
   input  logic             RST_N,
   input  logic             CLK,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [31:0]      IN_DINA,
   input  logic [31:0]      IN_DINB,
   input  logic             IN_SIGNED,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic [31:0]      DIV_DINA,
   output logic [31:0]      DIV_DINB,
   input  logic [31:0]      DIV_DOUT,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [31:0]      OUT_DATA,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             OUT_DIVZ
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam int c_ent_w = 32 + TAG_W + 1;
   localparam logic [c_cnt_w-1:0] c_depth = FIFO_DEPTH[c_cnt_w-1:0];

   // ------------------------------------------------------------------------
   // Parameter sanity. The FIFO must absorb a full pipeline of results plus
   // the registered-ready slack, otherwise back-to-back issue would stall.
   // ------------------------------------------------------------------------
   generate
      if (FIFO_DEPTH < DIV_LAT + 2) begin : g_depth_too_small
         $error("aq_div32_seq: FIFO_DEPTH must be >= DIV_LAT+2");
      end
      if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_not_pow2
         $error("aq_div32_seq: FIFO_DEPTH must be a power of two");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Handshakes and credit count
   // ------------------------------------------------------------------------
   logic               w_accept;
   logic               w_pop;
   logic               w_wr;
   logic               r_in_ready;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_next;

   assign w_accept = IN_VALID & r_in_ready;
   assign w_pop    = OUT_VALID & OUT_READY;
   assign IN_READY = r_in_ready;

   // r_cnt counts requests accepted but not yet popped, so it covers both
   // in-flight slots and buffered FIFO entries.
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_accept && !w_pop) begin
         w_cnt_next = r_cnt + 1'b1;
      end else if (!w_accept && w_pop) begin
         w_cnt_next = r_cnt - 1'b1;
      end
   end

   // Ready is registered from the next count, so a request accepted on this
   // edge is already reflected in the ready value for the next cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt      <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_in_ready <= (w_cnt_next < c_depth);
      end
   end

   // ------------------------------------------------------------------------
   // Operand conditioning
   // ------------------------------------------------------------------------
   logic [31:0] w_opa;
   logic [31:0] w_opb;
   logic        w_neg;
   logic        w_divz;

   assign w_divz = (IN_DINB == 32'd0);

`ifdef AQ_DIV_SIGNED_EN
   logic w_sign_a;
   logic w_sign_b;

   assign w_sign_a = IN_SIGNED & IN_DINA[31];
   assign w_sign_b = IN_SIGNED & IN_DINB[31];
   // Negating 32'h80000000 yields itself, which is the correct unsigned
   // magnitude, so the most-negative operand needs no special case.
   assign w_opa    = w_sign_a ? (32'd0 - IN_DINA) : IN_DINA;
   assign w_opb    = w_sign_b ? (32'd0 - IN_DINB) : IN_DINB;
   // A zero divisor always returns all-ones, so the sign is suppressed.
   assign w_neg    = (w_sign_a ^ w_sign_b) & ~w_divz;
`else
   logic unused_in_signed;

   assign unused_in_signed = IN_SIGNED;
   assign w_opa            = IN_DINA;
   assign w_opb            = IN_DINB;
   assign w_neg            = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Divider operand registers: load on accept, otherwise hold
   // ------------------------------------------------------------------------
   logic [31:0] r_div_dina;
   logic [31:0] r_div_dinb;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_div_dina <= '0;
         r_div_dinb <= '0;
      end else if (w_accept) begin
         r_div_dina <= w_opa;
         r_div_dinb <= w_opb;
      end
   end

   assign DIV_DINA = r_div_dina;
   assign DIV_DINB = r_div_dinb;

   // ------------------------------------------------------------------------
   // Side pipeline. Stage 0 loads on the accept edge, alongside the operand
   // registers. The last stage (index DIV_LAT) lines up with DIV_DOUT, so the
   // divider output and its flags are valid in the same cycle.
   // ------------------------------------------------------------------------
   logic             r_sv    [0:DIV_LAT];
   logic [TAG_W-1:0] r_stag  [0:DIV_LAT];
   logic             r_sneg  [0:DIV_LAT];
   logic             r_sdivz [0:DIV_LAT];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i <= DIV_LAT; i++) begin
            r_sv[i]    <= 1'b0;
            r_stag[i]  <= '0;
            r_sneg[i]  <= 1'b0;
            r_sdivz[i] <= 1'b0;
         end
      end else begin
         r_sv[0]    <= w_accept;
         r_stag[0]  <= IN_TAG;
         r_sneg[0]  <= w_neg;
         r_sdivz[0] <= w_divz;
         for (int i = 1; i <= DIV_LAT; i++) begin
            r_sv[i]    <= r_sv[i-1];
            r_stag[i]  <= r_stag[i-1];
            r_sneg[i]  <= r_sneg[i-1];
            r_sdivz[i] <= r_sdivz[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Quotient fixup
   // ------------------------------------------------------------------------
   logic [31:0]        w_fix_data;
   logic [c_ent_w-1:0] w_wr_entry;

   assign w_wr       = r_sv[DIV_LAT];
   assign w_fix_data = r_sdivz[DIV_LAT] ? 32'hFFFF_FFFF :
                       r_sneg[DIV_LAT]  ? (32'd0 - DIV_DOUT) : DIV_DOUT;
   assign w_wr_entry = {r_sdivz[DIV_LAT], r_stag[DIV_LAT], w_fix_data};

   // ------------------------------------------------------------------------
   // Output FIFO, first-word-fall-through. Storage needs no reset. Every read
   // is qualified by r_fill, which is reset.
   // ------------------------------------------------------------------------
   logic [c_ent_w-1:0] r_mem [0:FIFO_DEPTH-1];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_fill;
   logic [c_ent_w-1:0] w_head;

   always_ff @(posedge CLK) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   // Pointers are exactly log2(depth) bits wide, so they wrap naturally.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr && !w_pop) begin
            r_fill <= r_fill + 1'b1;
         end else if (!w_wr && w_pop) begin
            r_fill <= r_fill - 1'b1;
         end
      end
   end

   assign OUT_VALID = (r_fill != '0);
   assign w_head    = r_mem[r_rd_ptr];
   // Outputs read zero while the FIFO is empty. This also gives the
   // zero-after-reset values without resetting the storage array.
   assign {OUT_DIVZ, OUT_TAG, OUT_DATA} = OUT_VALID ? w_head : '0;

`ifndef SYNTHESIS
   // The credit limit makes this unreachable. It guards against a change
   // that breaks the relationship between r_cnt and r_fill.
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         assert (!(w_wr && (r_fill == c_depth)))
            else $error("aq_div32_seq: output FIFO written while full");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aq_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aq_div32_seq
//  Description : Self-checking bench for aq_div32_seq. It contains a
//                behavioural model of the divider pipeline and an arithmetic
//                reference model of the expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aq_div32_seq;

   localparam int DIV_LAT    = 33;
   localparam int FIFO_DEPTH = 64;
   localparam int TAG_W      = 4;
`ifdef AQ_DIV_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   typedef logic [32+TAG_W:0] res_t;   // {divz, tag, data}

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_dina = '0;
   logic [31:0]      in_dinb = '0;
   logic             in_signed = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [31:0]      div_dina;
   logic [31:0]      div_dinb;
   logic [31:0]      div_dout;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_divz;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aq_div32_seq #(.DIV_LAT(DIV_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .RST_N(rst_n), .CLK(clk),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DINA(in_dina), .IN_DINB(in_dinb), .IN_SIGNED(in_signed), .IN_TAG(in_tag),
      .DIV_DINA(div_dina), .DIV_DINB(div_dinb), .DIV_DOUT(div_dout),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_DATA(out_data), .OUT_TAG(out_tag), .OUT_DIVZ(out_divz)
   );

   // Divider model. The quotient of the operands loaded at edge E is on
   // DOUT after edge E+DIV_LAT. The model has no valid and no stall.
   logic [31:0] div_pipe [DIV_LAT];
   always @(posedge clk) begin
      div_pipe[0] <= (div_dinb == 32'd0) ? 32'hFFFF_FFFF : div_dina / div_dinb;
      for (int i = 1; i < DIV_LAT; i++) div_pipe[i] <= div_pipe[i-1];
   end
   assign div_dout = div_pipe[DIV_LAT-1];

   // Reference model: plain arithmetic on the request as issued.
   function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input logic [TAG_W-1:0] tag);
      longint sa;
      longint sb;
      logic [31:0] q;
      if (b == 32'd0) return {1'b1, tag, 32'hFFFF_FFFF};
      if (s & SIGNED_BUILD) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
      end else begin
         q = a / b;
      end
      return {1'b0, tag, q};
   endfunction

   // Monitor: records accepted requests (as expected results) and popped
   // results. Inputs change 1ns after posedge, so negedge sees stable values.
   res_t        exp_q[$];
   res_t        obs_q[$];
   int unsigned pop_cyc_q[$];
   int unsigned cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         obs_q.delete();
         pop_cyc_q.delete();
      end else begin
         if (in_valid && in_ready)
            exp_q.push_back(ref_result(in_dina, in_dinb, in_signed, in_tag));
         if (out_valid && out_ready) begin
            obs_q.push_back({out_divz, out_tag, out_data});
            pop_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic clear_queues();
      @(posedge clk); #1;
      exp_q.delete();
      obs_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic rand_req();
      in_dina   = $urandom;
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = TAG_W'($urandom);
      case ($urandom_range(0, 4))
         0:       in_dinb = $urandom;
         1:       in_dinb = $urandom_range(1, 255);
         2:       in_dinb = 32'd0 - $urandom_range(1, 255);
         3:       in_dinb = 32'd0;
         default: begin in_dina = 32'h8000_0000; in_dinb = 32'hFFFF_FFFF; end
      endcase
   endtask

   // Issues one request and waits for its result, returning the number of
   // edges from the accept edge to the first cycle with OUT_VALID high.
   task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [TAG_W-1:0] tag, output res_t res, output int lat);
      @(posedge clk); #1;
      in_valid = 1'b1; in_dina = a; in_dinb = b; in_signed = s; in_tag = tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      res = '0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            res = {out_divz, out_tag, out_data};
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data, out_tag, out_divz, div_dina, div_dinb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b vld=%b data=%h tag=%h divz=%b dina=%h dinb=%h want all zero",
                  in_ready, out_valid, out_data, out_tag, out_divz, div_dina, div_dinb);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_first_edge got %b want 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_release got %b want 1", in_ready);
      end
   endtask

   task automatic test_unsigned();
      res_t r;
      int   lat;
      run_one(32'd100, 32'd7, 1'b0, 4'd3, r, lat);
      checks++;
      if (r !== {1'b0, 4'd3, 32'd14}) begin
         errors++; $display("FAIL unsigned_100_7 got %h want %h", r, {1'b0, 4'd3, 32'd14});
      end
      checks++;
      if (lat !== 34) begin
         errors++; $display("FAIL latency got %0d want 34", lat);
      end
   endtask

   task automatic test_signed();
      res_t r;
      int   lat;
      logic [31:0] want;
      want = SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'h2492_4916;
      run_one(32'hFFFF_FF9C, 32'd7, 1'b1, 4'd5, r, lat);
      checks++;
      if (r !== {1'b0, 4'd5, want}) begin
         errors++; $display("FAIL signed_m100_7 got %h want %h", r, {1'b0, 4'd5, want});
      end
      want = SIGNED_BUILD ? 32'h8000_0000 : 32'h0000_0000;
      run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd9, r, lat);
      checks++;
      if (r !== {1'b0, 4'd9, want}) begin
         errors++; $display("FAIL signed_min_m1 got %h want %h", r, {1'b0, 4'd9, want});
      end
      want = SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'h0000_0000;
      run_one(32'd100, 32'hFFFF_FFF9, 1'b1, 4'd1, r, lat);
      checks++;
      if (r !== {1'b0, 4'd1, want}) begin
         errors++; $display("FAIL signed_100_m7 got %h want %h", r, {1'b0, 4'd1, want});
      end
      run_one(32'hFFFF_FF9C, 32'd7, 1'b0, 4'd2, r, lat);
      checks++;
      if (r !== {1'b0, 4'd2, 32'h2492_4916}) begin
         errors++; $display("FAIL unsigned_flag_ignored got %h want %h", r, {1'b0, 4'd2, 32'h2492_4916});
      end
   endtask

   task automatic test_divz();
      res_t r;
      int   lat;
      run_one(32'd5, 32'd0, 1'b0, 4'd7, r, lat);
      checks++;
      if (r !== {1'b1, 4'd7, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL divz_5_0 got %h want %h", r, {1'b1, 4'd7, 32'hFFFF_FFFF});
      end
      run_one(32'd9, 32'd3, 1'b0, 4'd8, r, lat);
      checks++;
      if (r !== {1'b0, 4'd8, 32'd3}) begin
         errors++; $display("FAIL after_divz_9_3 got %h want %h", r, {1'b0, 4'd8, 32'd3});
      end
      run_one(32'hFFFF_FFFB, 32'd0, 1'b1, 4'd4, r, lat);
      checks++;
      if (r !== {1'b1, 4'd4, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL divz_signed got %h want %h", r, {1'b1, 4'd4, 32'hFFFF_FFFF});
      end
   endtask

   task automatic test_back_to_back();
      int drops = 0;
      int mism  = 0;
      int first = -1;
      int gaps  = 0;
      out_ready = 1'b1;
      clear_queues();
      for (int i = 0; i < 1000; i++) begin
         in_valid = 1'b1;
         rand_req();
         @(negedge clk);
         if (in_ready !== 1'b1) drops++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (drops != 0) begin
         errors++; $display("FAIL b2b_ready_drops got %0d want 0", drops);
      end
      for (int k = 0; k < 200 && obs_q.size() < 1000; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (obs_q.size() != 1000 || exp_q.size() != 1000) begin
         errors++; $display("FAIL b2b_count got obs=%0d exp=%0d want 1000", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         if (obs_q[i] !== exp_q[i]) begin
            mism++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (mism != 0) begin
         errors++;
         $display("FAIL b2b_data got %0d mismatches, first at %0d obs=%h want %h",
                  mism, first, obs_q[first], exp_q[first]);
      end
      for (int i = 1; i < pop_cyc_q.size(); i++)
         if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) gaps++;
      checks++;
      if (gaps != 0) begin
         errors++; $display("FAIL b2b_throughput got %0d gaps want 0", gaps);
      end
   endtask

   task automatic test_backpressure();
      int   accepted = 0;
      int   mism = 0;
      res_t head;
      clear_queues();
      out_ready = 1'b0;
      for (int i = 0; i < 120; i++) begin
         in_valid = 1'b1;
         rand_req();
         @(negedge clk);
         if (in_ready) accepted++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (accepted != FIFO_DEPTH) begin
         errors++; $display("FAIL bp_accepted got %0d want %0d", accepted, FIFO_DEPTH);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_ready_low got %b want 0", in_ready);
      end
      head = {out_divz, out_tag, out_data};
      repeat (5) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {out_divz, out_tag, out_data} !== head || head !== exp_q[0]) begin
         errors++;
         $display("FAIL bp_head_stable got vld=%b %h (earlier %h) want %h",
                  out_valid, {out_divz, out_tag, out_data}, head, exp_q[0]);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int k = 0; k < 200 && (obs_q.size() < FIFO_DEPTH || out_valid); k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_reassert got %b want 1", in_ready);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      checks++;
      if (obs_q.size() != FIFO_DEPTH || exp_q.size() != FIFO_DEPTH || mism != 0) begin
         errors++;
         $display("FAIL bp_drain got obs=%0d exp=%0d mismatches=%0d want %0d/%0d/0",
                  obs_q.size(), exp_q.size(), mism, FIFO_DEPTH, FIFO_DEPTH);
      end
   endtask

   task automatic test_reset_midflight();
      int n = 0;
      int mism = 0;
      int bad = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         rand_req();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL midreset_outputs got %0d cycles with valid/ready high want 0", bad);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 20 && n < 3; k++) begin
         in_valid = 1'b1;
         rand_req();
         @(negedge clk);
         if (in_ready) n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      checks++;
      if (n != 3 || obs_q.size() != 3 || exp_q.size() != 3 || mism != 0) begin
         errors++;
         $display("FAIL midreset_results got accepted=%0d obs=%0d exp=%0d mismatches=%0d want 3/3/3/0",
                  n, obs_q.size(), exp_q.size(), mism);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_divz();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
